// File: rtl/aes_word_loader.sv
// aes_word_loader: packs 32-bit words into AES-128 key/plaintext blocks, tracks in-flight blocks, returns ciphertext; AES_LOADER_ERRCNT_EN adds err_cnt
module aes_word_loader #(
  parameter int PIPE_LAT = 12,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_is_key,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_data_out,
  output logic         m_valid,
  output logic [127:0] m_data,
  output logic         frame_err,
  output logic         busy
`ifdef AES_LOADER_ERRCNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t         state_q, state_d;
  logic           blk_type_q, blk_type_d;
  logic [1:0]     w_q, w_d, widx;
  logic [95:0]    shadow_q, shadow_d;
  logic [127:0]   key_q, key_d, din_q, din_d, m_data_q, m_data_d;
  logic [PIPE_LAT:0] tag_q, tag_d;
  logic           m_valid_q, frame_err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           accept, restart, commit, pt_commit;
  assign busy         = cnt_q != '0;
  assign s_ready      = !(s_is_key && busy);
  assign accept       = s_valid && s_ready;
  assign restart      = state_q == COLLECT && s_is_key != blk_type_q;
  assign commit       = accept && state_q == COLLECT && !restart && w_q == 2'd3;
  assign pt_commit    = commit && !blk_type_q;
  assign widx         = (state_q == IDLE || restart) ? 2'd0 : w_q;
  assign core_key     = key_q;
  assign core_data_in = din_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign frame_err    = frame_err_q;
  // Word framing: a type switch mid-block restarts the block with the offending beat as word 0
  always_comb begin
    state_d    = state_q;
    blk_type_d = blk_type_q;
    w_d        = w_q;
    shadow_d   = shadow_q;
    key_d      = key_q;
    din_d      = din_q;
    if (accept) begin
      blk_type_d = (state_q == IDLE || restart) ? s_is_key : blk_type_q;
      for (int i = 0; i < 3; i++)
        if (widx == 2'(i)) shadow_d[95-32*i -: 32] = s_data;
      state_d = commit ? IDLE : COLLECT;
      w_d     = commit ? 2'd0 : widx + 2'd1;
      key_d   = (commit && blk_type_q) ? {shadow_q, s_data} : key_q;
      din_d   = pt_commit ? {shadow_q, s_data} : din_q;
    end
  end
  // Tag line carries one stage past the core latency so data_out is sampled PIPE_LAT+1 edges after issue
  always_comb begin
    tag_d    = {tag_q[PIPE_LAT-1:0], pt_commit};
    m_data_d = tag_q[PIPE_LAT] ? core_data_out : m_data_q;
    cnt_d    = cnt_q + CNT_W'(pt_commit) - CNT_W'(m_valid_q);
  end
  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      blk_type_q  <= 1'b0;
      w_q         <= 2'd0;
      shadow_q    <= '0;
      key_q       <= '0;
      din_q       <= '0;
      tag_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      blk_type_q  <= blk_type_d;
      w_q         <= w_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      din_q       <= din_d;
      tag_q       <= tag_d;
      m_valid_q   <= tag_q[PIPE_LAT];
      m_data_q    <= m_data_d;
      frame_err_q <= accept && restart;
      cnt_q       <= cnt_d;
    end
  end
`ifdef AES_LOADER_ERRCNT_EN
  logic [7:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
  // Saturating count of framing errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= 8'd0;
    else if (frame_err_q && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
  end
`endif
endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: randomized and directed checks against a block-level model with an AES-128 core stand-in
module tb_aes_word_loader;
  localparam int PL = 12;
  logic         clk = 1'b0;
  logic         rst, s_valid, s_ready, s_is_key, m_valid, frame_err, busy;
  logic [31:0]  s_data;
  logic [127:0] core_data_in, core_key, core_data_out, m_data, core_ct, last_m;
  logic [127:0] pipe [PL];
`ifdef AES_LOADER_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int mcnt, merr, last_due, stalls, commit_cyc;
  logic         mtype;
  logic [127:0] mbuf, mkey, mdin, saved;
  logic [127:0] exp_data [$];
  int           exp_due [$];
  int           pulses [$];

  aes_word_loader #(.PIPE_LAT(PL), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_is_key(s_is_key), .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .m_valid(m_valid), .m_data(m_data),
    .frame_err(frame_err), .busy(busy)
`ifdef AES_LOADER_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xt(a);
    end
    return r;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv, p, t, s;
    inv = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gm(inv, p);
      p = gm(p, p);
    end
    s = inv;
    t = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s ^= t;
    end
    return s ^ 8'h63;
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc, a0, a1, a2, a3;
    logic [7:0] b [16];
    logic [7:0] u [16];
    logic [127:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sb(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) u[4*c+j] = b[4*((c+j)%4)+j];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = u[i];
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // Stand-in pipelined core: result appears PL edges after data_in/key change
  always_comb core_ct = aes_enc(core_key, core_data_in);
  always @(posedge clk) begin
    for (int i = PL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= core_ct;
  end
  assign core_data_out = pipe[PL-1];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b0;
    mcnt = 0; merr = 0; mbuf = '0; mkey = '0; mdin = '0; mtype = 1'b0;
    exp_data.delete(); exp_due.delete(); last_due = -1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_din", core_data_in, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
`ifdef AES_LOADER_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one beat from a negedge, wait for acceptance, then apply it to the block model
  task automatic beat(input logic [31:0] d, input logic k);
    int n;
    logic ferr;
    s_valid = 1'b1; s_data = d; s_is_key = k; n = 0;
    #1;
    while (!s_ready && n < 100) begin
      check("s_ready_stall", s_ready, !(k && last_due >= cyc));
      @(negedge clk);
      #1;
      n++;
    end
    stalls = n;
    if (n >= 100) begin
      check("stall_timeout", n, 0);
      s_valid = 1'b0;
      return;
    end
    check("s_ready", s_ready, !(k && last_due >= cyc));
    @(posedge clk);
    @(negedge clk);
    ferr = 1'b0;
    if (mcnt != 0 && k != mtype) begin
      ferr = 1'b1;
      mcnt = 0;
      merr = (merr == 255) ? 255 : merr + 1;
    end
    if (mcnt == 0) mtype = k;
    mbuf[127-32*mcnt -: 32] = d;
    mcnt++;
    if (mcnt == 4) begin
      mcnt = 0;
      commit_cyc = cyc;
      if (mtype) mkey = mbuf;
      else begin
        mdin = mbuf;
        exp_data.push_back(aes_enc(mkey, mbuf));
        exp_due.push_back(cyc + PL + 1);
        last_due = cyc + PL + 1;
      end
    end
    check("frame_err", frame_err, ferr);
    check("core_key", core_key, mkey);
    check("core_din", core_data_in, mdin);
  endtask

  task automatic block(input logic [127:0] v, input logic k);
    for (int i = 0; i < 4; i++) beat(v[127-32*i -: 32], k);
  endtask

  // Per-cycle result monitor against the model's due list
  initial forever begin
    logic ev;
    @(negedge clk);
    #2;
    ev = exp_due.size() > 0 && exp_due[0] == cyc;
    check("m_valid", m_valid, ev);
    check("busy", busy, last_due >= cyc);
    if (m_valid) pulses.push_back(cyc);
    if (ev) begin
      check("m_data", m_data, exp_data[0]);
      last_m = m_data;
    end
    if (exp_due.size() > 0 && exp_due[0] <= cyc) begin
      void'(exp_due.pop_front());
      void'(exp_data.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    s_valid = 1'b0; s_data = '0; s_is_key = 1'b0; rst = 1'b0; last_due = -1;
    @(negedge clk);
    do_reset();
    block(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    check("key_load", core_key, 128'h000102030405060708090a0b0c0d0e0f);
    pulses.delete();
    block(128'h00112233445566778899aabbccddeeff, 1'b0);
    idle(16);
    check("fips_ct", last_m, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("latency", pulses.size() > 0 ? pulses[0] - commit_cyc : -1, PL + 1);
    pulses.delete();
    block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle(20);
    check("b2b_count", pulses.size(), 2);
    check("b2b_gap", pulses.size() == 2 ? pulses[1] - pulses[0] : -1, 4);
    block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    beat(32'h2b7e1516, 1'b1);
    check("key_stall_len", stalls, PL + 2);
    beat(32'h28aed2a6, 1'b1);
    beat(32'habf71588, 1'b1);
    beat(32'h09cf4f3c, 1'b1);
    block(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
    idle(20);
    check("fips_ct2", last_m, 128'h3925841d02dc09fbdc118597196a0b32);
    saved = core_data_in;
    beat($urandom, 1'b0);
    beat($urandom, 1'b0);
    beat($urandom, 1'b1);
    check("frame_err_pulse", frame_err, 1);
    beat($urandom, 1'b1);
    check("frame_err_drop", frame_err, 0);
    beat($urandom, 1'b1);
    beat($urandom, 1'b1);
    idle(2);
    check("din_kept", core_data_in, saved);
`ifdef AES_LOADER_ERRCNT_EN
    check("err_cnt_one", err_cnt, 1);
`endif
    block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle(5);
    do_reset();
    pulses.delete();
    block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle(20);
    check("post_reset_pulses", pulses.size(), 1);
    for (int i = 0; i < 400; i++) begin
      beat($urandom, $urandom_range(0, 9) < 2);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(30);
    check("drained", exp_due.size(), 0);
`ifdef AES_LOADER_ERRCNT_EN
    check("err_cnt_final", err_cnt, merr);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
